fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage of the pipelined LC-3b core, directly upstream of the IF/ID register. Owns the architectural fetch PC, runs the instruction-memory read/resp handshake, and buffers fetched instructions in a small queue. Decode pulls from the queue with a valid/ready handshake. Redirects from later stages flush the queue and restart fetch; a read already in flight is drained and its data discarded.

## Interface
- `RESET_PC`, default 16'h0000: fetch address after reset; bit 0 must be 0.
- `DEPTH`, default 2: queue entries; power of two, at least 2.

- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `redirect` in 1: flush the queue and restart fetch at `redirect_target`.
- `redirect_target` in 16 (`lc3b_word`): new fetch PC; bit 0 is ignored and forced to 0.
- `imem_read` out 1: instruction-memory read request.
- `imem_address` out 16: read address; stable while `imem_read` is 1.
- `imem_resp` in 1: one-cycle pulse; read data is valid in this cycle.
- `imem_rdata` in 16: instruction word.
- `out_valid` out 1: queue head is valid.
- `out_ready` in 1: decode accepts the queue head.
- `out_instr` out 16: head instruction.
- `out_pc` out 16: address of the head instruction.
- `out_pc_plus2` out 16: `out_pc + 2`, mod 2^16.

## Operation
- **State registers:**
  - `state` ∈ {IDLE, REQ, DISCARD}
  - `pc`: next address to fetch
  - `req_addr`: address of the in-flight read
  - queue `count`, head and tail pointers
- **Reset values:**
  - state=IDLE, pc=RESET_PC, req_addr=RESET_PC, count=0
  - imem_read=0, imem_address=RESET_PC, out_valid=0
  - out_instr, out_pc and out_pc_plus2 read 0
- **Output decode:**
  - imem_read = (state≠IDLE)
  - imem_address = req_addr
  - out_valid = (count≠0) && !redirect
- **Pop:** occurs when out_valid && out_ready. Redirect suppresses it.
- **IDLE:**
  - If count−pop < DEPTH → REQ, with req_addr←pc.
  - Otherwise stay in IDLE.
- **REQ, on imem_resp:**
  - Push {req_addr, imem_rdata}; pc←pc+2.
  - If count+1−pop = DEPTH → IDLE.
  - Otherwise stay in REQ with req_addr←pc+2. The read stays asserted, giving back-to-back fetch.
- **REQ, no imem_resp:** hold.
- **DISCARD:**
  - Hold until imem_resp, then drop the data and go to REQ with req_addr←pc.
  - No push occurs in DISCARD.
- **Redirect (highest priority, any state):**
  - count←0; pc←{target[15:1],0}.
  - REQ without imem_resp → DISCARD. The read stays asserted at the old req_addr.
  - REQ with imem_resp in the same cycle → data dropped; REQ with req_addr←target.
  - IDLE → REQ with req_addr←target.
  - DISCARD without imem_resp → stay in DISCARD (pc updated to the latest target).
  - DISCARD with imem_resp → REQ with req_addr←target.
- **Overflow:** cannot occur. REQ is entered only when there is space, and REQ exits to IDLE once the queue is full.
- **Arithmetic:** all PC values are 16-bit unsigned. 16'hFFFE + 2 wraps to 16'h0000, including `out_pc_plus2`.

## Timing
- **Fetch latency:** reset deasserted → imem_read=1 one clock later, with address RESET_PC.
- **Queue latency:** imem_resp in cycle N → out_valid in cycle N+1. There is no bypass.
- **Redirect latency:**
  - With no read in flight, the new read is issued in the cycle after redirect.
  - With a read in flight, it is issued the cycle after that read's imem_resp.
- **Handshake:** imem_read, once raised, is never dropped before imem_resp.
- **Same-cycle push and pop:** allowed; count is unchanged.
- **Reset mid-read:** state is cleared immediately. The memory controller is reset by the same `reset`.

## Structure
- **`lc3b_types` additions:**
  - `lc3b_fetch_entry` packed struct {lc3b_word pc; lc3b_word instr;}
  - `lc3b_fetch_state` enum {FETCH_IDLE, FETCH_REQ, FETCH_DISCARD}
- **`fetch_queue` sub-module:** parameterized FIFO of `lc3b_fetch_entry` with push, pop, flush and count. Async reset.
- **Top level:** the state machine, the PC registers and the +2 adders.

## Test plan
- **Reset and cold fetch:** reset, memory answers after 3 cycles with 16'h1234, out_ready=1 → imem_address=0000; out_instr=1234, out_pc=0000, out_pc_plus2=0002 one cycle after resp; next read at address 0002.
- **Backpressure:** out_ready=0, DEPTH=2, memory answers immediately → two entries (0000, 0002) queued, then imem_read=0 with state IDLE. Raise out_ready for one cycle → fetch of 0004 issued the next cycle.
- **Redirect during an outstanding read:** redirect=1 with target 16'h0401 while the read of 0002 is pending → read held at 0002; its response is dropped; next imem_address=0400; no out_valid until 0400 is returned.
- **Redirect coincident with imem_resp, queue non-empty:** data dropped, queue cleared, out_valid=0 in that cycle, and the read of the target is issued the next cycle.
- **Wrap-around:** redirect to 16'hFFFE → out_pc=FFFE, out_pc_plus2=0000, next fetch at 0000.
- **Asynchronous reset asserted mid-read:** imem_read and out_valid go to 0 without a clock edge; fetch restarts at RESET_PC after reset is released.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared LC-3b types for the fetch stage.
// Word, queue entry and fetch FSM state.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef struct packed {
        lc3b_word pc;
        lc3b_word instr;
    } lc3b_fetch_entry;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_DISCARD
    } lc3b_fetch_state;

    function automatic lc3b_word pc_inc(lc3b_word a);
        return a + 16'd2;
    endfunction

endpackage

// File: rtl/fetch_unit_queue.sv
// Small FIFO of fetched {pc, instr} entries.
// Flush empties it in one cycle and wins over push/pop.
module fetch_queue
    import lc3b_types::*;
#(
    parameter int DEPTH = 2,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            push,
    input  lc3b_fetch_entry push_data,
    input  logic            pop,
    output lc3b_fetch_entry head,
    output logic [CW-1:0]   count
);

    lc3b_fetch_entry mem [DEPTH];
    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;

    // Storage write; contents are don't-care while the queue is empty.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[tail_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) tail_ptr <= tail_ptr + 1'b1;
            if (pop)  head_ptr <= head_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[head_ptr];

endmodule

// File: rtl/fetch_unit.sv
// LC-3b instruction fetch stage: PC, imem handshake,
// and a small queue feeding decode.
module fetch_unit
    import lc3b_types::*;
#(
    parameter lc3b_word RESET_PC = 16'h0000,
    parameter int       DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [15:0] redirect_target,
    output logic        imem_read,
    output logic [15:0] imem_address,
    input  logic        imem_resp,
    input  logic [15:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic [15:0] out_pc,
    output logic [15:0] out_pc_plus2
);

    localparam int CW = $clog2(DEPTH) + 1;

    lc3b_fetch_state state, state_n;
    lc3b_word        pc, pc_n;
    lc3b_word        req_addr, req_addr_n;
    lc3b_word        target;

    logic            push, pop, flush, empty;
    logic [CW-1:0]   count, occ_after_pop;
    lc3b_fetch_entry head, push_data;

    assign target        = redirect_target & 16'hFFFE;
    assign empty         = (count == '0);
    assign out_valid     = !empty && !redirect;
    assign pop           = out_valid && out_ready;
    assign occ_after_pop = count - CW'(pop);
    assign push_data     = '{pc: req_addr, instr: imem_rdata};

    assign imem_read     = (state != FETCH_IDLE);
    assign imem_address  = req_addr;

    assign out_instr     = empty ? 16'h0000 : head.instr;
    assign out_pc        = empty ? 16'h0000 : head.pc;
    assign out_pc_plus2  = empty ? 16'h0000 : pc_inc(head.pc);

    // State, fetch PC and in-flight address registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FETCH_IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            req_addr <= req_addr_n;
        end
    end

    // Next-state logic; redirect overrides everything and a read
    // already on the bus is always drained before a new one.
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        req_addr_n = req_addr;
        push       = 1'b0;
        flush      = 1'b0;
        if (redirect) begin
            flush = 1'b1;
            pc_n  = target;
            unique case (state)
                FETCH_IDLE: begin
                    state_n    = FETCH_REQ;
                    req_addr_n = target;
                end
                FETCH_REQ,
                FETCH_DISCARD: begin
                    if (imem_resp) begin
                        state_n    = FETCH_REQ;
                        req_addr_n = target;
                    end else begin
                        state_n = FETCH_DISCARD;
                    end
                end
                default: state_n = FETCH_IDLE;
            endcase
        end else begin
            unique case (state)
                FETCH_IDLE: begin
                    if (occ_after_pop < CW'(DEPTH)) begin
                        state_n    = FETCH_REQ;
                        req_addr_n = pc;
                    end
                end
                FETCH_REQ: begin
                    if (imem_resp) begin
                        push = 1'b1;
                        pc_n = pc_inc(pc);
                        if (occ_after_pop + 1'b1 == CW'(DEPTH)) begin
                            state_n = FETCH_IDLE;
                        end else begin
                            req_addr_n = pc_inc(pc);
                        end
                    end
                end
                FETCH_DISCARD: begin
                    if (imem_resp) begin
                        state_n    = FETCH_REQ;
                        req_addr_n = pc;
                    end
                end
                default: state_n = FETCH_IDLE;
            endcase
        end
    end

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .head     (head),
        .count    (count)
    );

endmodule
